fetch_unit: RTL and testbench

Instruction-fetch stage directly downstream of the program counter register in the dynamic pipeline CPU. It consumes the current PC and drives the PC register's enable, so the PC advances only when a fetch is issued or a redirect occurs. It issues word fetches to instruction memory over a req/ack handshake and buffers returned instructions in a small FIFO. Decode pulls instructions from that FIFO over a valid/ready handshake. On a branch/jump redirect it flushes the FIFO and discards any in-flight response.

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_unit.sv | 196 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bundle: PC-register link, instruction-memory req/ack bus and
// decode valid/ready channel. The fetch unit sits on the master side.
interface fetch_if;
  logic [31:0] pc_in;
  logic        pc_enable;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc4;

  modport master (
    input  pc_in, redirect, imem_ack, imem_rdata, dec_ready,
    output pc_enable, imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc4
  );

  modport slave (
    output pc_in, redirect, imem_ack, imem_rdata, dec_ready,
    input  pc_enable, imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc4
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, DEPTH-entry FIFO to decode,
// redirect flush. Optional counters under FETCH_PERF_EN.
module fetch_unit #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clock,
  input  logic        reset,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_dropped
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [1:0]       r_state;
  logic             r_imem_req;
  logic [31:0]      r_imem_addr;
  logic [31:0]      r_mem_instr [DEPTH];
  logic [31:0]      r_mem_pc    [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_dec_valid;
  logic [31:0]      r_dec_instr;
  logic [31:0]      r_dec_pc;
  logic [31:0]      r_dec_pc4;

  logic             w_pop;
  logic             w_push;
  logic [PTR_W:0]   w_occ_next;
  logic             w_credit;
  logic             w_issue;
  logic [PTR_W-1:0] w_rd_ptr_next;
  logic [PTR_W-1:0] w_wr_ptr_next;
  logic [PTR_W:0]   w_count_next;
  logic [31:0]      w_head_instr;
  logic [31:0]      w_head_pc;

  assign w_pop      = r_dec_valid & bus.dec_ready & ~bus.redirect;
  assign w_push     = bus.imem_ack & (r_state == S_WAIT) & ~bus.redirect;
  assign w_occ_next = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
  assign w_credit   = (w_occ_next < DEPTH_C);
  // Gated by reset so nothing is issued (and the PC does not load) while held in reset.
  assign w_issue    = reset & ~bus.redirect & w_credit &
                      ((r_state == S_IDLE) | ((r_state == S_WAIT) & bus.imem_ack));

  assign bus.pc_enable = reset & (w_issue | bus.redirect);
  assign bus.imem_req  = r_imem_req;
  assign bus.imem_addr = r_imem_addr;
  assign bus.dec_valid = r_dec_valid;
  assign bus.dec_instr = r_dec_instr;
  assign bus.dec_pc    = r_dec_pc;
  assign bus.dec_pc4   = r_dec_pc4;

  // Next FIFO pointers/occupancy and the entry that will sit at the head after this edge.
  always_comb begin
    w_rd_ptr_next = r_rd_ptr;
    w_wr_ptr_next = r_wr_ptr;
    w_count_next  = r_count;
    w_head_instr  = 32'd0;
    w_head_pc     = 32'd0;
    if (bus.redirect) begin
      w_rd_ptr_next = {PTR_W{1'b0}};
      w_wr_ptr_next = {PTR_W{1'b0}};
      w_count_next  = {(PTR_W+1){1'b0}};
    end else begin
      w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);
      w_wr_ptr_next = r_wr_ptr + PTR_W'(w_push);
      w_count_next  = w_occ_next;
    end
    if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
      w_head_instr = bus.imem_rdata;
      w_head_pc    = r_imem_addr;
    end else begin
      w_head_instr = r_mem_instr[w_rd_ptr_next];
      w_head_pc    = r_mem_pc[w_rd_ptr_next];
    end
  end

  // Request FSM: tracks the single outstanding fetch and whether its response is kept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_imem_req  <= 1'b0;
      r_imem_addr <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state     <= S_WAIT;
            r_imem_req  <= 1'b1;
            r_imem_addr <= bus.pc_in;
          end
        end
        S_WAIT: begin
          if (bus.redirect) begin
            if (bus.imem_ack) begin
              r_state    <= S_IDLE;
              r_imem_req <= 1'b0;
            end else begin
              r_state <= S_DROP;
            end
          end else if (bus.imem_ack) begin
            if (w_issue) begin
              r_imem_addr <= bus.pc_in;
            end else begin
              r_state    <= S_IDLE;
              r_imem_req <= 1'b0;
            end
          end
        end
        S_DROP: begin
          if (bus.imem_ack) begin
            r_state    <= S_IDLE;
            r_imem_req <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= 32'd0;
        r_mem_pc[i]    <= 32'd0;
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W+1){1'b0}};
    end else begin
      if (w_push) begin
        r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
        r_mem_pc[r_wr_ptr]    <= r_imem_addr;
      end
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
    end
  end

  // Registered decode head; fields keep their last value whenever the FIFO goes empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dec_valid <= 1'b0;
      r_dec_instr <= 32'd0;
      r_dec_pc    <= 32'd0;
      r_dec_pc4   <= 32'd4;
    end else begin
      r_dec_valid <= (w_count_next != {(PTR_W+1){1'b0}});
      if (w_count_next != {(PTR_W+1){1'b0}}) begin
        r_dec_instr <= w_head_instr;
        r_dec_pc    <= w_head_pc;
        r_dec_pc4   <= w_head_pc + 32'd4;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0]    r_perf_stall;
  logic [31:0]    r_perf_dropped;
  logic           w_resp_drop;
  logic [PTR_W:0] w_flush_cnt;

  assign w_resp_drop = bus.imem_ack & ((r_state == S_DROP) | ((r_state == S_WAIT) & bus.redirect));
  assign w_flush_cnt = bus.redirect ? r_count : {(PTR_W+1){1'b0}};
  assign perf_stall_cycles = r_perf_stall;
  assign perf_dropped      = r_perf_dropped;

  // Stall and discard counters, free-running with natural wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_stall   <= 32'd0;
      r_perf_dropped <= 32'd0;
    end else begin
      if ((r_state == S_IDLE) && !w_credit && !bus.redirect) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      r_perf_dropped <= r_perf_dropped + 32'(w_resp_drop) + 32'(w_flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: PC register and instruction memory models around the DUT.
module tb_fetch_unit;
  localparam logic [31:0] KEY = 32'hA5A5_5A5A;
  localparam logic [31:0] A0  = 32'h0040_0000;

  logic        clk;
  logic        rst_n;
  int          n_cmp;
  int          n_bad;
  int          mem_lat;
  int          w_cnt;
  logic        poison;
  logic [31:0] pc_rst;
  logic [31:0] tgt;
  logic [31:0] log_pc[$];
  logic [31:0] log_instr[$];

  fetch_if u_if();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_dropped;
  fetch_unit #(.DEPTH(2), .PTR_W(1)) dut (.clock(clk), .reset(rst_n), .bus(u_if),
    .perf_stall_cycles(perf_stall_cycles), .perf_dropped(perf_dropped));
`else
  fetch_unit #(.DEPTH(2), .PTR_W(1)) dut (.clock(clk), .reset(rst_n), .bus(u_if));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register: loads the redirect target or PC+4 when enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) u_if.pc_in <= pc_rst;
    else if (u_if.pc_enable) u_if.pc_in <= u_if.redirect ? tgt : u_if.pc_in + 32'd4;
  end

  // Instruction memory: acks mem_lat cycles into each request.
  always @(negedge clk) begin
    if (!rst_n || !u_if.imem_req) begin
      u_if.imem_ack = 1'b0;
      w_cnt = 0;
    end else begin
      if (u_if.imem_ack) w_cnt = 0;
      w_cnt++;
      if (w_cnt >= mem_lat) begin
        u_if.imem_ack   = 1'b1;
        u_if.imem_rdata = poison ? 32'hDEAD_BEEF : (u_if.imem_addr ^ KEY);
      end else begin
        u_if.imem_ack = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    #3;
    if (rst_n && u_if.dec_valid && u_if.dec_ready && !u_if.redirect) begin
      log_pc.push_back(u_if.dec_pc);
      log_instr.push_back(u_if.dec_instr);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [31:0] pc0, input logic rdy, input int lat);
    rst_n = 1'b0; u_if.redirect = 1'b0; u_if.dec_ready = rdy;
    mem_lat = lat; poison = 1'b0; pc_rst = pc0;
    cyc(); cyc();
    log_pc.delete(); log_instr.delete();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    u_if.redirect = 1'b1;
    #1;
    n_cmp++; if (u_if.pc_enable !== 1'b0) begin n_bad++; $display("FAIL rst_pc_enable: got %b want 0", u_if.pc_enable); end
    n_cmp++; if (u_if.imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", u_if.imem_req); end
    n_cmp++; if (u_if.imem_addr !== 32'd0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", u_if.imem_addr); end
    n_cmp++; if (u_if.dec_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", u_if.dec_valid); end
    n_cmp++; if (u_if.dec_instr !== 32'd0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", u_if.dec_instr); end
    n_cmp++; if (u_if.dec_pc !== 32'd0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", u_if.dec_pc); end
    n_cmp++; if (u_if.dec_pc4 !== 32'd4) begin n_bad++; $display("FAIL rst_pc4: got %h want 4", u_if.dec_pc4); end
    u_if.redirect = 1'b0;
  endtask

  task automatic test_stream();
    do_reset(A0, 1'b1, 1);
    #1;
    n_cmp++; if (u_if.pc_enable !== 1'b1) begin n_bad++; $display("FAIL stream_first_en: got %b want 1", u_if.pc_enable); end
    cyc();
    n_cmp++; if (u_if.imem_req !== 1'b1) begin n_bad++; $display("FAIL stream_req: got %b want 1", u_if.imem_req); end
    n_cmp++; if (u_if.imem_addr !== A0) begin n_bad++; $display("FAIL stream_addr0: got %h want %h", u_if.imem_addr, A0); end
    cyc();
    n_cmp++; if (u_if.dec_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid: got %b want 1", u_if.dec_valid); end
    n_cmp++; if (u_if.dec_pc !== A0) begin n_bad++; $display("FAIL stream_pc: got %h want %h", u_if.dec_pc, A0); end
    n_cmp++; if (u_if.dec_pc4 !== A0 + 32'd4) begin n_bad++; $display("FAIL stream_pc4: got %h want %h", u_if.dec_pc4, A0 + 32'd4); end
    n_cmp++; if (u_if.dec_instr !== (A0 ^ KEY)) begin n_bad++; $display("FAIL stream_instr: got %h want %h", u_if.dec_instr, A0 ^ KEY); end
    repeat (7) cyc();
    n_cmp++; if (log_pc.size() !== 7) begin n_bad++; $display("FAIL stream_rate: got %0d pops want 7", log_pc.size()); end
    n_cmp++; if (u_if.imem_addr !== A0 + 32'd32) begin n_bad++; $display("FAIL stream_addr8: got %h want %h", u_if.imem_addr, A0 + 32'd32); end
    for (int i = 0; i < 7 && i < log_pc.size(); i++) begin
      n_cmp++;
      if (log_pc[i] !== A0 + 32'(4 * i) || log_instr[i] !== ((A0 + 32'(4 * i)) ^ KEY)) begin
        n_bad++; $display("FAIL stream_order[%0d]: got pc %h instr %h want pc %h", i, log_pc[i], log_instr[i], A0 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(A0, 1'b0, 1);
    repeat (10) cyc();
    n_cmp++; if (u_if.imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req: got %b want 0", u_if.imem_req); end
    n_cmp++; if (u_if.pc_enable !== 1'b0) begin n_bad++; $display("FAIL bp_pc_enable: got %b want 0", u_if.pc_enable); end
    n_cmp++; if (u_if.pc_in !== A0 + 32'd8) begin n_bad++; $display("FAIL bp_fetch_count: pc_in %h want %h", u_if.pc_in, A0 + 32'd8); end
    n_cmp++; if (u_if.dec_valid !== 1'b1 || u_if.dec_pc !== A0) begin n_bad++; $display("FAIL bp_head: valid %b pc %h want 1 %h", u_if.dec_valid, u_if.dec_pc, A0); end
    u_if.dec_ready = 1'b1;
    #1;
    n_cmp++; if (u_if.pc_enable !== 1'b1) begin n_bad++; $display("FAIL bp_full_pop_issue: got %b want 1", u_if.pc_enable); end
    repeat (8) cyc();
    n_cmp++; if (log_pc.size() !== 8) begin n_bad++; $display("FAIL bp_pops: got %0d want 8", log_pc.size()); end
    for (int i = 0; i < 8 && i < log_pc.size(); i++) begin
      n_cmp++;
      if (log_pc[i] !== A0 + 32'(4 * i)) begin n_bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, log_pc[i], A0 + 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect_drop();
    logic seen_bad;
    seen_bad = 1'b0;
    do_reset(A0, 1'b1, 3);
    cyc();
    tgt = 32'h0040_0100;
    u_if.redirect = 1'b1;
    #1;
    n_cmp++; if (u_if.pc_enable !== 1'b1) begin n_bad++; $display("FAIL drop_redir_en: got %b want 1", u_if.pc_enable); end
    cyc();
    u_if.redirect = 1'b0;
    #1;
    n_cmp++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== A0) begin n_bad++; $display("FAIL drop_hold: req %b addr %h want 1 %h", u_if.imem_req, u_if.imem_addr, A0); end
    n_cmp++; if (u_if.pc_enable !== 1'b0) begin n_bad++; $display("FAIL drop_no_issue: got %b want 0", u_if.pc_enable); end
    poison = 1'b1;
    cyc();
    poison = 1'b0;
    n_cmp++; if (u_if.pc_enable !== 1'b0) begin n_bad++; $display("FAIL drop_ack_no_issue: got %b want 0", u_if.pc_enable); end
    cyc();
    n_cmp++; if (u_if.imem_req !== 1'b0 || u_if.pc_enable !== 1'b1) begin n_bad++; $display("FAIL drop_idle: req %b en %b want 0 1", u_if.imem_req, u_if.pc_enable); end
    cyc();
    n_cmp++; if (u_if.imem_addr !== 32'h0040_0100) begin n_bad++; $display("FAIL drop_new_addr: got %h want 00400100", u_if.imem_addr); end
    for (int i = 0; i < 5; i++) begin
      if (u_if.dec_instr === 32'hDEAD_BEEF) seen_bad = 1'b1;
      cyc();
    end
    if (u_if.dec_instr === 32'hDEAD_BEEF) seen_bad = 1'b1;
    n_cmp++; if (seen_bad !== 1'b0) begin n_bad++; $display("FAIL drop_leak: stale data seen %b want 0", seen_bad); end
    n_cmp++; if (log_pc.size() !== 1) begin n_bad++; $display("FAIL drop_pops: got %0d want 1", log_pc.size()); end
    if (log_pc.size() > 0) begin
      n_cmp++; if (log_pc[0] !== 32'h0040_0100 || log_instr[0] !== (32'h0040_0100 ^ KEY)) begin n_bad++; $display("FAIL drop_first: got %h %h want 00400100", log_pc[0], log_instr[0]); end
    end
  endtask

  task automatic test_redirect_ack();
    do_reset(A0, 1'b0, 1);
    cyc(); cyc();
    tgt = 32'h0040_0200;
    u_if.redirect = 1'b1;
    #1;
    n_cmp++; if (u_if.pc_enable !== 1'b1) begin n_bad++; $display("FAIL rack_en: got %b want 1", u_if.pc_enable); end
    cyc();
    u_if.redirect = 1'b0;
    #1;
    n_cmp++; if (u_if.dec_valid !== 1'b0) begin n_bad++; $display("FAIL rack_flush: valid %b want 0", u_if.dec_valid); end
    n_cmp++; if (u_if.imem_req !== 1'b0 || u_if.pc_enable !== 1'b1) begin n_bad++; $display("FAIL rack_idle: req %b en %b want 0 1", u_if.imem_req, u_if.pc_enable); end
    u_if.dec_ready = 1'b1;
    repeat (3) cyc();
    n_cmp++; if (log_pc.size() !== 1) begin n_bad++; $display("FAIL rack_pops: got %0d want 1", log_pc.size()); end
    if (log_pc.size() > 0) begin
      n_cmp++; if (log_pc[0] !== 32'h0040_0200) begin n_bad++; $display("FAIL rack_first: got %h want 00400200", log_pc[0]); end
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset(32'hFFFF_FFFC, 1'b1, 1);
    cyc();
    n_cmp++; if (u_if.imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_addr: got %h want fffffffc", u_if.imem_addr); end
    cyc();
    n_cmp++; if (u_if.dec_pc !== 32'hFFFF_FFFC || u_if.dec_pc4 !== 32'd0) begin n_bad++; $display("FAIL wrap_pc4: pc %h pc4 %h want fffffffc 0", u_if.dec_pc, u_if.dec_pc4); end
    mem_lat = 5;
    cyc();
    n_cmp++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'd4) begin n_bad++; $display("FAIL wrap_wait: req %b addr %h want 1 4", u_if.imem_req, u_if.imem_addr); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (u_if.imem_req !== 1'b0 || u_if.imem_addr !== 32'd0) begin n_bad++; $display("FAIL midrst_req: req %b addr %h want 0 0", u_if.imem_req, u_if.imem_addr); end
    n_cmp++; if (u_if.dec_valid !== 1'b0 || u_if.dec_instr !== 32'd0) begin n_bad++; $display("FAIL midrst_dec: valid %b instr %h want 0 0", u_if.dec_valid, u_if.dec_instr); end
    n_cmp++; if (u_if.dec_pc !== 32'd0 || u_if.dec_pc4 !== 32'd4) begin n_bad++; $display("FAIL midrst_pc: pc %h pc4 %h want 0 4", u_if.dec_pc, u_if.dec_pc4); end
    n_cmp++; if (u_if.pc_enable !== 1'b0) begin n_bad++; $display("FAIL midrst_en: got %b want 0", u_if.pc_enable); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; mem_lat = 1; w_cnt = 0; poison = 1'b0;
    pc_rst = 32'd0; tgt = 32'd0;
    u_if.redirect = 1'b0; u_if.dec_ready = 1'b0;
    u_if.imem_ack = 1'b0; u_if.imem_rdata = 32'd0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_ack();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
